// File: rtl/pong_pkg.sv
// pong_pkg: shared FSM encoding, playfield defaults and centring helper for the ball engine
package pong_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_POINT = 2'd3;
    localparam int DEF_POS_W            = 10;
    localparam int DEF_SCREEN_W         = 640;
    localparam int DEF_SCREEN_H         = 480;
    localparam int DEF_BALL_SIZE        = 8;
    localparam int DEF_PADDLE_H         = 72;
    localparam int DEF_P1_X_EDGE        = 32;
    localparam int DEF_P2_X_EDGE        = 600;
    localparam int DEF_INIT_SPEED       = 2;
    localparam int DEF_MAX_SPEED        = 6;
    localparam int DEF_HITS_PER_SPEEDUP = 4;
    localparam int DEF_SERVE_DELAY      = 60;
    function automatic int centre(input int extent, input int size);
        return (extent - size) / 2;
    endfunction
endpackage

// File: rtl/ball_axis.sv
// ball_axis: one-axis signed step, clamped to [0,LIMIT], with edge-reached flags
module ball_axis #(
    parameter int POS_W = 10,
    parameter int LIMIT = 472
) (
    input  logic [POS_W-1:0]        pos,
    input  logic                    dir,
    input  logic [2:0]              step,
    output logic signed [POS_W+1:0] nxt,
    output logic [POS_W-1:0]        clamped,
    output logic                    at_lo,
    output logic                    at_hi
);
    localparam logic signed [POS_W+1:0] LIM = (POS_W+2)'(LIMIT);
    logic signed [POS_W+1:0] pos_s;
    logic signed [POS_W+1:0] step_s;
    always_comb begin
        pos_s   = $signed({2'b00, pos});
        step_s  = $signed({{(POS_W-1){1'b0}}, step});
        nxt     = dir ? pos_s + step_s : pos_s - step_s;
        at_lo   = nxt[POS_W+1] || nxt == '0;
        at_hi   = nxt >= LIM;
        clamped = at_lo ? '0 : at_hi ? LIM[POS_W-1:0] : nxt[POS_W-1:0];
    end
endmodule

// File: rtl/ball_engine.sv
// ball_engine: frame-stepped Pong ball mover with serve FSM, zoned paddle deflection,
// progressive speed-up and one-clock score pulses
module ball_engine
    import pong_pkg::*;
#(
    parameter int POS_W            = DEF_POS_W,
    parameter int SCREEN_W         = DEF_SCREEN_W,
    parameter int SCREEN_H         = DEF_SCREEN_H,
    parameter int BALL_SIZE        = DEF_BALL_SIZE,
    parameter int PADDLE_H         = DEF_PADDLE_H,
    parameter int P1_X_EDGE        = DEF_P1_X_EDGE,
    parameter int P2_X_EDGE        = DEF_P2_X_EDGE,
    parameter int INIT_SPEED       = DEF_INIT_SPEED,
    parameter int MAX_SPEED        = DEF_MAX_SPEED,
    parameter int HITS_PER_SPEEDUP = DEF_HITS_PER_SPEEDUP,
    parameter int SERVE_DELAY      = DEF_SERVE_DELAY
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             refresh_tick,
    input  logic             start,
    input  logic             pause,
    input  logic [POS_W-1:0] paddle1_y,
    input  logic [POS_W-1:0] paddle2_y,
    output logic [POS_W-1:0] ball_x,
    output logic [POS_W-1:0] ball_y,
    output logic             dir_x,
    output logic             dir_y,
    output logic [2:0]       speed,
    output logic [7:0]       rally_count,
    output logic [1:0]       state,
    output logic             score_p1,
    output logic             score_p2
);
    localparam int CNT_W = $clog2(SERVE_DELAY);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(SERVE_DELAY - 1);
    localparam logic [POS_W-1:0]        X_C      = POS_W'(centre(SCREEN_W, BALL_SIZE));
    localparam logic [POS_W-1:0]        Y_C      = POS_W'(centre(SCREEN_H, BALL_SIZE));
    localparam logic [POS_W-1:0]        P1_X     = POS_W'(P1_X_EDGE);
    localparam logic [POS_W-1:0]        P2_X     = POS_W'(P2_X_EDGE);
    localparam logic signed [POS_W+1:0] P1_S     = (POS_W+2)'(P1_X_EDGE);
    localparam logic signed [POS_W+1:0] P2_S     = (POS_W+2)'(P2_X_EDGE);
    localparam logic signed [POS_W+1:0] BS       = (POS_W+2)'(BALL_SIZE);
    localparam logic signed [POS_W+1:0] HALF     = (POS_W+2)'(BALL_SIZE / 2);
    localparam logic signed [POS_W+1:0] PH       = (POS_W+2)'(PADDLE_H);
    localparam logic signed [POS_W+1:0] THIRD    = (POS_W+2)'(PADDLE_H / 3);
    localparam logic signed [POS_W+1:0] THIRD2   = (POS_W+2)'(2 * (PADDLE_H / 3));
    localparam logic [2:0]              SPD_INIT = 3'(INIT_SPEED);
    localparam logic [2:0]              SPD_MAX  = 3'(MAX_SPEED);
    localparam logic [7:0]              HPS      = 8'(HITS_PER_SPEEDUP);

    logic [POS_W-1:0] x_q, x_d, y_q, y_d;
    logic             dx_q, dx_d, dy_q, dy_d, sc1_q, sc1_d, sc2_q, sc2_d;
    logic [2:0]       spd_q, spd_d;
    logic [7:0]       rally_q, rally_d, rally_inc;
    logic [1:0]       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic signed [POS_W+1:0] x_nxt, y_nxt, pad, by, rel;
    logic [POS_W-1:0] x_clamp, y_clamp;
    logic             x_lo, x_hi, y_lo, y_hi, hit;

    ball_axis #(.POS_W(POS_W), .LIMIT(SCREEN_W - BALL_SIZE)) u_axis_x (
        .pos(x_q), .dir(dx_q), .step(spd_q),
        .nxt(x_nxt), .clamped(x_clamp), .at_lo(x_lo), .at_hi(x_hi)
    );
    ball_axis #(.POS_W(POS_W), .LIMIT(SCREEN_H - BALL_SIZE)) u_axis_y (
        .pos(y_q), .dir(dy_q), .step(spd_q),
        .nxt(y_nxt), .clamped(y_clamp), .at_lo(y_lo), .at_hi(y_hi)
    );

    // Only the paddle the ball is heading toward can be hit, so one overlap/zone compare serves both.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        spd_d     = spd_q;
        rally_d   = rally_q;
        st_d      = st_q;
        cnt_d     = cnt_q;
        sc1_d     = 1'b0;
        sc2_d     = 1'b0;
        pad       = $signed({2'b00, dx_q ? paddle2_y : paddle1_y});
        by        = $signed({2'b00, y_q});
        rel       = by + HALF - pad;
        hit       = (by + BS > pad) && (by < pad + PH) && (dx_q ? x_nxt >= P2_S : x_nxt <= P1_S);
        rally_inc = rally_q == 8'hff ? rally_q : rally_q + 8'd1;
        if (!pause && st_q == ST_POINT) begin
            st_d  = ST_SERVE;
            cnt_d = '0;
        end else if (!pause && refresh_tick) begin
            if (st_q != ST_IDLE && !start) begin
                st_d    = ST_IDLE;
                x_d     = X_C;
                y_d     = Y_C;
                dx_d    = 1'b1;
                dy_d    = 1'b1;
                spd_d   = SPD_INIT;
                rally_d = '0;
                cnt_d   = '0;
            end else if (st_q == ST_IDLE) begin
                st_d  = start ? ST_SERVE : ST_IDLE;
                cnt_d = '0;
            end else if (st_q == ST_SERVE) begin
                st_d  = cnt_q == CNT_LAST ? ST_PLAY : ST_SERVE;
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                x_d  = x_clamp;
                y_d  = y_clamp;
                dy_d = y_lo ? 1'b1 : y_hi ? 1'b0 : dy_q;
                if (hit) begin
                    x_d     = dx_q ? P2_X : P1_X;
                    dx_d    = ~dx_q;
                    dy_d    = rel < THIRD ? 1'b0 : rel >= THIRD2 ? 1'b1 : dy_d;
                    rally_d = rally_inc;
                    if (rally_q != 8'hff && rally_inc % HPS == 8'd0 && spd_q != SPD_MAX)
                        spd_d = spd_q + 3'd1;
                end else if (x_lo || x_hi) begin
                    st_d    = ST_POINT;
                    sc1_d   = x_hi;
                    sc2_d   = x_lo;
                    x_d     = X_C;
                    y_d     = Y_C;
                    dx_d    = x_hi;
                    dy_d    = 1'b1;
                    spd_d   = SPD_INIT;
                    rally_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q     <= X_C;
            y_q     <= Y_C;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            spd_q   <= SPD_INIT;
            rally_q <= '0;
            st_q    <= ST_IDLE;
            cnt_q   <= '0;
            sc1_q   <= 1'b0;
            sc2_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            spd_q   <= spd_d;
            rally_q <= rally_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            sc1_q   <= sc1_d;
            sc2_q   <= sc2_d;
        end
    end

    assign ball_x      = x_q;
    assign ball_y      = y_q;
    assign dir_x       = dx_q;
    assign dir_y       = dy_q;
    assign speed       = spd_q;
    assign rally_count = rally_q;
    assign state       = st_q;
    assign score_p1    = sc1_q;
    assign score_p2    = sc2_q;
endmodule
